// File: rtl/sp_sync_ram_pkg.sv
// Shared widths and word/address types for the single-port SRAM model.
package sp_sync_ram_pkg;

    localparam int ADDR_W_DEF = 8;
    localparam int DATA_W_DEF = 8;

    typedef logic [ADDR_W_DEF-1:0] addr_t;
    typedef logic [DATA_W_DEF-1:0] word_t;

endpackage

// File: rtl/sp_sync_ram_array.sv
// Storage array: synchronous clear, synchronous write, combinational read
// (or a registered read port when REG_READ_EN is defined).
module sp_sync_ram_array
    import sp_sync_ram_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF,
    parameter int DEPTH  = 2**ADDR_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
`ifdef REG_READ_EN
    input  logic              rd_capture,
`endif
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [DEPTH];

    // Reset wins over a coincident write.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (we) begin
            mem[addr] <= wdata;
        end
    end

`ifdef REG_READ_EN
    logic [DATA_W-1:0] rd_q;

    // Writes never touch rd_q; only a read cycle refreshes it.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_q <= '0;
        end else if (rd_capture) begin
            rd_q <= mem[addr];
        end
    end

    assign rdata = rd_q;
`else
    assign rdata = mem[addr];
`endif

endmodule

// File: rtl/sp_sync_ram.sv
// Single-port SRAM with active-low controls and a shared tri-state data bus.
// Optional REG_READ_EN selects a one-cycle registered read instead of combinational.
module sp_sync_ram
    import sp_sync_ram_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF,
    parameter int DEPTH  = 2**ADDR_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              n_rw,
    input  logic              n_cs,
    input  logic              n_oe,
    input  logic [ADDR_W-1:0] addr,
    inout  wire  [DATA_W-1:0] data
);

    logic              we;
    logic              rd_en;
    logic [DATA_W-1:0] rd_data;

    assign we    = ~n_cs & n_rw;
    assign rd_en = ~n_cs & ~n_rw & ~n_oe;

    sp_sync_ram_array #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_array (
        .clk        (clk),
        .rst        (rst),
        .we         (we),
`ifdef REG_READ_EN
        .rd_capture (~n_cs & ~n_rw),
`endif
        .addr       (addr),
        .wdata      (data),
        .rdata      (rd_data)
    );

    // Drive only in a true read so a writing master never sees contention.
    assign data = rd_en ? rd_data : {DATA_W{1'bz}};

endmodule

// File: tb/tb_sp_sync_ram.sv
// Self-checking bench for sp_sync_ram: scoreboard of expected read data
// against a 256-entry reference model; works with or without REG_READ_EN.
module tb_sp_sync_ram;

    logic       clk = 1'b0;
    logic       rst;
    logic       n_rw;
    logic       n_cs;
    logic       n_oe;
    logic [7:0] addr;
    logic [7:0] tb_data;
    logic       tb_drive;
    wire  [7:0] data_bus;

    logic [7:0] model [256];
    logic [7:0] exp_q [$];
    int         n_cmp = 0;
    int         n_bad = 0;

    assign data_bus = tb_drive ? tb_data : 8'hzz;

    always #5 clk = ~clk;

    sp_sync_ram dut (
        .clk  (clk),
        .rst  (rst),
        .n_rw (n_rw),
        .n_cs (n_cs),
        .n_oe (n_oe),
        .addr (addr),
        .data (data_bus)
    );

    task automatic idle();
        n_cs     = 1'b1;
        n_rw     = 1'b0;
        n_oe     = 1'b1;
        tb_drive = 1'b0;
    endtask

    task automatic do_write(input logic [7:0] a, input logic [7:0] d);
        @(negedge clk);
        n_cs = 1'b0; n_rw = 1'b1; n_oe = 1'b0;
        addr = a; tb_data = d; tb_drive = 1'b1;
        @(posedge clk);
        #1;
        if (!rst) model[a] = d;
        idle();
    endtask

    // Read is sampled just after the edge while controls are still held,
    // which is valid for both the combinational and the registered read.
    task automatic do_read(input logic [7:0] a, input string tag);
        logic [7:0] exp;
        @(negedge clk);
        n_cs = 1'b0; n_rw = 1'b0; n_oe = 1'b0;
        addr = a; tb_drive = 1'b0;
        exp_q.push_back(model[a]);
        @(posedge clk);
        #1;
        exp = exp_q.pop_front();
        n_cmp++;
        if (data_bus !== exp) begin
            n_bad++;
            $display("FAIL %s addr=%02h got=%02h expected=%02h", tag, a, data_bus, exp);
        end
        idle();
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        for (int i = 0; i < 256; i++) model[i] = 8'h00;
        rst = 1'b0;
        do_read(8'h00, "reset_addr00");
        do_read(8'hFF, "reset_addrFF");
    endtask

    task automatic test_write_read();
        do_write(8'd10, 8'hA5);
        do_read(8'd10, "wr_rd_10");
        do_write(8'd20, 8'h5A);
        do_read(8'd20, "wr_rd_20");
        do_read(8'd10, "reread_10");
    endtask

    // A releasing RAM leaves the bench's 0x00 intact; a driving RAM
    // corrupts it (contention / wired value) since addr 10 holds 0xA5.
    task automatic test_bus_release();
        logic [2:0] cfg [3];
        string      nm  [3];
        cfg[0] = 3'b100; nm[0] = "release_cs";
        cfg[1] = 3'b001; nm[1] = "release_oe";
        cfg[2] = 3'b111; nm[2] = "release_cs_rw_oe";
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            {n_cs, n_rw, n_oe} = cfg[k];
            addr = 8'd10; tb_data = 8'h00; tb_drive = 1'b1;
            #2;
            n_cmp++;
            if (data_bus !== 8'h00) begin
                n_bad++;
                $display("FAIL %s got=%02h expected=00", nm[k], data_bus);
            end
            @(posedge clk);
            #1;
            idle();
        end
        // During a real write the bus must carry exactly the master's value.
        @(negedge clk);
        n_cs = 1'b0; n_rw = 1'b1; n_oe = 1'b0;
        addr = 8'd30; tb_data = 8'h3C; tb_drive = 1'b1;
        #2;
        n_cmp++;
        if (data_bus !== 8'h3C) begin
            n_bad++;
            $display("FAIL write_no_drive got=%02h expected=3c", data_bus);
        end
        @(posedge clk);
        #1;
        model[30] = 8'h3C;
        idle();
        do_read(8'd30, "write_during_oe0");
        do_read(8'd10, "after_release_10");
    endtask

    task automatic test_deselected_write();
        @(negedge clk);
        n_cs = 1'b1; n_rw = 1'b1; n_oe = 1'b0;
        addr = 8'd10; tb_data = 8'hFF; tb_drive = 1'b1;
        @(posedge clk);
        #1;
        idle();
        do_read(8'd10, "deselected_write");
    endtask

    task automatic test_back_to_back();
        do_write(8'h44, 8'hC3);
        do_read(8'h44, "b2b_44");
        do_write(8'h44, 8'h3C);
        do_read(8'h44, "b2b_44_overwrite");
    endtask

    task automatic test_random();
        logic [7:0] a;
        logic [7:0] d;
        for (int i = 0; i < 24; i++) begin
            a = 8'($urandom_range(0, 255));
            d = 8'($urandom_range(0, 255));
            if (i == 0) a = 8'h00;
            if (i == 1) a = 8'hFF;
            do_write(a, d);
            do_read(a, "rand_pair");
        end
        for (int i = 0; i < 8; i++) begin
            a = 8'($urandom_range(0, 255));
            do_read(a, "rand_scan");
        end
        do_read(8'h00, "rand_edge_00");
        do_read(8'hFF, "rand_edge_FF");
    endtask

    task automatic test_reset_with_write();
        do_write(8'h33, 8'h77);
        do_read(8'h33, "pre_rst_33");
        @(negedge clk);
        rst = 1'b1;
        n_cs = 1'b0; n_rw = 1'b1; n_oe = 1'b0;
        addr = 8'h33; tb_data = 8'h99; tb_drive = 1'b1;
        @(posedge clk);
        #1;
        for (int i = 0; i < 256; i++) model[i] = 8'h00;
        rst = 1'b0;
        idle();
        do_read(8'h33, "rst_beats_write");
        do_read(8'd10, "rst_cleared_10");
    endtask

    initial begin
        rst = 1'b0;
        addr = 8'h00;
        tb_data = 8'h00;
        idle();
        for (int i = 0; i < 256; i++) model[i] = 8'h00;
        test_reset();
        test_write_read();
        test_bus_release();
        test_deselected_write();
        test_back_to_back();
        test_random();
        test_reset_with_write();
        repeat (2) @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
